// File: rtl/score_keeper_pkg.sv
// Shared types and defaults for the score keeper and its BCD arithmetic.
package score_keeper_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned POINTS_W         = 11;
  localparam int unsigned SCORE_DIGITS_DEF = 5;
  localparam int unsigned BONUS_DIGIT_DEF  = 4;
  localparam int unsigned INIT_LIVES_DEF   = 3;
  localparam int unsigned MAX_LIVES_DEF    = 9;

  typedef enum logic [1:0] {SK_IDLE, SK_ADD, SK_DONE} sk_state_t;

  // Digit idx of a points word; the hundreds field is only 3 bits wide.
  function automatic bcd_digit_t points_digit(input logic [POINTS_W-1:0] pts,
                                              input int unsigned         idx);
    bcd_digit_t d;
    case (idx)
      0:       d = pts[3:0];
      1:       d = pts[7:4];
      2:       d = {1'b0, pts[10:8]};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry, purely combinational.
module bcd_digit_add
  import score_keeper_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > 5'd9);
    sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
  end

endmodule

// File: rtl/score_keeper.sv
// Accumulates per-frame BCD point pulses into a serial BCD score and owns
// lives, bonus-life award, game-over and high score.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = SCORE_DIGITS_DEF,
  parameter int unsigned BONUS_DIGIT  = BONUS_DIGIT_DEF,
  parameter int unsigned INIT_LIVES   = INIT_LIVES_DEF,
  parameter int unsigned MAX_LIVES    = MAX_LIVES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      game_begin,
  input  logic [POINTS_W-1:0]       ast_points,
  input  logic                      ship_lost,
  output logic [SCORE_DIGITS*4-1:0] score,
  output logic [SCORE_DIGITS*4-1:0] high_score,
  output logic [3:0]                lives,
  output logic                      extra_life,
  output logic                      game_over,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned SW    = SCORE_DIGITS * 4;
  localparam int unsigned IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_DIGITS - 1);
  localparam logic [3:0]       INIT_L   = 4'(INIT_LIVES);
  localparam logic [3:0]       MAX_L    = 4'(MAX_LIVES);

  sk_state_t           state_q, state_d;
  logic [SW-1:0]       work_q, work_d;
  logic [SW-1:0]       score_q, score_d;
  logic [SW-1:0]       hs_q, hs_d;
  logic [POINTS_W-1:0] addend_q, addend_d;
  logic [POINTS_W-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                bonus_q, bonus_d;
  logic [3:0]          lives_q, lives_d;
  logic                go_q, go_d;
  logic                xl_q, xl_d;
  logic                ovf_q, ovf_d;

  bcd_digit_t          cur_digit, add_digit, dsum;
  logic                dcout;
  logic                req, lose, award, go_rise, load;
  logic                at_last, at_bonus;
  logic [POINTS_W-1:0] load_val;

  always_comb begin
    cur_digit = work_q[4*idx_q +: 4];
    add_digit = points_digit(addend_q, 32'(idx_q));
    at_last   = (idx_q == LAST_IDX);
    at_bonus  = ((32'(idx_q) + 32'd1) == BONUS_DIGIT);
  end

  bcd_digit_add u_digit_add (
    .a    (cur_digit),
    .b    (add_digit),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SK_IDLE;
      work_q     <= '0;
      score_q    <= '0;
      hs_q       <= '0;
      addend_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      bonus_q    <= 1'b0;
      lives_q    <= '0;
      go_q       <= 1'b1;
      xl_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      score_q    <= score_d;
      hs_q       <= hs_d;
      addend_q   <= addend_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      bonus_q    <= bonus_d;
      lives_q    <= lives_d;
      go_q       <= go_d;
      xl_q       <= xl_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    score_d    = score_q;
    hs_d       = hs_q;
    addend_d   = addend_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    bonus_d    = bonus_q;
    lives_d    = lives_q;
    go_d       = go_q;
    ovf_d      = ovf_q;
    xl_d       = 1'b0;
    load       = 1'b0;
    load_val   = ast_points;

    req   = (ast_points != '0) && !go_q;
    lose  = ship_lost && !go_q;
    award = (state_q == SK_DONE) && bonus_q;

    case (state_q)
      SK_IDLE: begin
        load = req;
      end
      SK_ADD: begin
        work_d[4*idx_q +: 4] = dsum;
        carry_d              = dcout;
        if (at_bonus && dcout) bonus_d = 1'b1;
        if (at_last) begin
          if (dcout) ovf_d = 1'b1;
          state_d = SK_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (req) begin
          if (pend_vld_q) begin
            ovf_d = 1'b1;
          end else begin
            pend_vld_d = 1'b1;
            pend_d     = ast_points;
          end
        end
      end
      SK_DONE: begin
        score_d = work_q;
        // A request landing on DONE either refills the freed pending slot
        // or, with nothing pending, starts directly.
        if (pend_vld_q) begin
          load       = 1'b1;
          load_val   = pend_q;
          pend_vld_d = req;
          pend_d     = ast_points;
        end else if (req) begin
          load = 1'b1;
        end else begin
          state_d = SK_IDLE;
        end
      end
      default: state_d = SK_IDLE;
    endcase

    if (load) begin
      addend_d = load_val;
      idx_d    = '0;
      carry_d  = 1'b0;
      bonus_d  = 1'b0;
      state_d  = SK_ADD;
    end

    xl_d = award;
    if (award && !lose) begin
      lives_d = (lives_q >= MAX_L) ? MAX_L : lives_q + 4'd1;
    end else if (lose && !award) begin
      lives_d = lives_q - 4'd1;
      if (lives_q == 4'd1) go_d = 1'b1;
    end

    // High-score compare waits for an in-flight add to reach DONE.
    go_rise = go_d && !go_q;
    if (state_q == SK_IDLE && go_rise && (score_q > hs_q)) hs_d = score_q;
    if (state_q == SK_DONE && (go_q || go_rise) && (work_q > hs_q)) hs_d = work_q;

    if (game_begin) begin
      state_d    = SK_IDLE;
      work_d     = '0;
      score_d    = '0;
      hs_d       = hs_q;
      pend_vld_d = 1'b0;
      idx_d      = '0;
      carry_d    = 1'b0;
      bonus_d    = 1'b0;
      lives_d    = INIT_L;
      go_d       = 1'b0;
      ovf_d      = 1'b0;
      xl_d       = 1'b0;
    end
  end

  assign score      = score_q;
  assign high_score = hs_q;
  assign lives      = lives_q;
  assign extra_life = xl_q;
  assign game_over  = go_q;
  assign busy       = (state_q != SK_IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper against a transaction-level queue model.
module tb_score_keeper;

  localparam int SCORE_MOD = 100000;
  localparam int BONUS_MOD = 10000;
  localparam int MAXL      = 9;
  localparam int INITL     = 3;
  localparam int SERVICE   = 6;

  logic        clk = 1'b0;
  logic        reset, game_begin, ship_lost;
  logic [10:0] ast_points;
  logic [19:0] score, high_score;
  logic [3:0]  lives;
  logic        extra_life, game_over, busy, overflow;

  int n_cmp = 0;
  int n_fail = 0;

  // model state: integer score, queue-of-one pending job, service countdown
  int m_score, m_hs, m_lives, m_go, m_xl, m_ovf, m_rem, m_pend_vld, m_pend, m_job;

  always #5 clk = ~clk;

  score_keeper #(
    .SCORE_DIGITS (5),
    .BONUS_DIGIT  (4),
    .INIT_LIVES   (3),
    .MAX_LIVES    (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .game_begin (game_begin),
    .ast_points (ast_points),
    .ship_lost  (ship_lost),
    .score      (score),
    .high_score (high_score),
    .lives      (lives),
    .extra_life (extra_life),
    .game_over  (game_over),
    .busy       (busy),
    .overflow   (overflow)
  );

  function automatic int pts_val(input logic [10:0] p);
    return int'(p[3:0]) + 10 * int'(p[7:4]) + 100 * int'(p[10:8]);
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          t;
    t = v;
    for (int unsigned i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_hs = 0; m_lives = 0; m_go = 1; m_xl = 0;
    m_ovf = 0; m_rem = 0; m_pend_vld = 0; m_pend = 0; m_job = 0;
  endtask

  task automatic model_step(input logic gb, input logic [10:0] pts, input logic sl);
    int acc, lose, bonus, sum, old_go, rem_old, v;
    if (gb) begin
      m_score = 0; m_rem = 0; m_pend_vld = 0; m_lives = INITL;
      m_go = 0; m_ovf = 0; m_xl = 0;
      return;
    end
    v       = pts_val(pts);
    acc     = (pts != 11'd0 && m_go == 0) ? 1 : 0;
    lose    = (sl && m_go == 0) ? 1 : 0;
    old_go  = m_go;
    rem_old = m_rem;
    bonus   = 0;
    if (m_rem == 1) begin
      sum   = m_score + m_job;
      bonus = ((sum / BONUS_MOD) != (m_score / BONUS_MOD)) ? 1 : 0;
      if (sum >= SCORE_MOD) m_ovf = 1;
      m_score = sum % SCORE_MOD;
      if (m_pend_vld != 0) begin
        m_job = m_pend; m_rem = SERVICE;
        m_pend_vld = acc; m_pend = v;
      end else if (acc != 0) begin
        m_job = v; m_rem = SERVICE;
      end else begin
        m_rem = 0;
      end
    end else if (m_rem > 1) begin
      m_rem--;
      if (acc != 0) begin
        if (m_pend_vld != 0) m_ovf = 1;
        else begin m_pend_vld = 1; m_pend = v; end
      end
    end else if (acc != 0) begin
      m_job = v; m_rem = SERVICE;
    end
    m_xl = bonus;
    if (bonus != 0 && lose == 0) begin
      m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
    end else if (lose != 0 && bonus == 0) begin
      m_lives--;
      if (m_lives == 0) m_go = 1;
    end
    if ((old_go == 0 && m_go == 1 && rem_old == 0) || (rem_old == 1 && m_go == 1))
      if (m_score > m_hs) m_hs = m_score;
  endtask

  task automatic cyc(input logic gb, input logic [10:0] pts, input logic sl);
    game_begin = gb; ast_points = pts; ship_lost = sl;
    @(posedge clk);
    model_step(gb, pts, sl);
    #1;
    game_begin = 1'b0; ast_points = '0; ship_lost = 1'b0;
  endtask

  task automatic idle_until_model_done();
    while (m_rem != 0) cyc(1'b0, 11'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; game_begin = 1'b0; ast_points = '0; ship_lost = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (score !== 20'h0) begin n_fail++; $display("FAIL rst_score got %h expected %h", score, 20'h0); end
    n_cmp++;
    if (high_score !== 20'h0) begin n_fail++; $display("FAIL rst_hs got %h expected %h", high_score, 20'h0); end
    n_cmp++;
    if (lives !== 4'd0) begin n_fail++; $display("FAIL rst_lives got %0d expected 0", lives); end
    n_cmp++;
    if (game_over !== 1'b1) begin n_fail++; $display("FAIL rst_game_over got %b expected 1", game_over); end
    n_cmp++;
    if (extra_life !== 1'b0) begin n_fail++; $display("FAIL rst_extra_life got %b expected 0", extra_life); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b expected 0", busy); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b expected 0", overflow); end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    int nb;
    cyc(1'b1, 11'd0, 1'b0);
    if (lives !== 4'd3) begin n_fail++; $display("FAIL begin_lives got %0d expected 3", lives); end
    n_cmp++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL begin_game_over got %b expected 0", game_over); end
    n_cmp++;
    if (score !== 20'h0) begin n_fail++; $display("FAIL begin_score got %h expected 0", score); end
    n_cmp++;
    cyc(1'b0, 11'h010, 1'b0);
    nb = 0;
    for (int j = 1; j <= 7; j++) begin
      if (busy === 1'b1) nb++;
      if (j < 7) begin
        if (score !== 20'h0) begin n_fail++; $display("FAIL single_hold cyc %0d got %h expected 0", j, score); end
        n_cmp++;
        cyc(1'b0, 11'd0, 1'b0);
      end else begin
        if (score !== 20'h00010) begin n_fail++; $display("FAIL single_score got %h expected 00010", score); end
        n_cmp++;
      end
    end
    if (nb != 6) begin n_fail++; $display("FAIL single_busy_cycles got %0d expected 6", nb); end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] es;
    logic        eb;
    cyc(1'b1, 11'd0, 1'b0);
    cyc(1'b0, 11'h020, 1'b0);
    cyc(1'b0, 11'd0, 1'b0);
    cyc(1'b0, 11'h050, 1'b0);
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_pre got %b expected 0", overflow); end
    n_cmp++;
    cyc(1'b0, 11'h030, 1'b0);
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_drop_ovf got %b expected 1", overflow); end
    n_cmp++;
    for (int k = 4; k <= 13; k++) begin
      es = (k < 7) ? 20'h0 : ((k < 13) ? 20'h00020 : 20'h00070);
      eb = (k <= 12);
      if (score !== es) begin n_fail++; $display("FAIL b2b_score k=%0d got %h expected %h", k, score, es); end
      n_cmp++;
      if (busy !== eb) begin n_fail++; $display("FAIL b2b_busy k=%0d got %b expected %b", k, busy, eb); end
      n_cmp++;
      if (k < 13) cyc(1'b0, 11'd0, 1'b0);
    end
  endtask

  task automatic test_game_over();
    cyc(1'b1, 11'd0, 1'b0);
    cyc(1'b0, 11'h270, 1'b0);
    idle_until_model_done();
    if (score !== 20'h00270) begin n_fail++; $display("FAIL go_score got %h expected 00270", score); end
    n_cmp++;
    for (int n = 1; n <= 3; n++) begin
      cyc(1'b0, 11'd0, 1'b1);
      if (lives !== 4'(3 - n)) begin n_fail++; $display("FAIL go_lives n=%0d got %0d expected %0d", n, lives, 3 - n); end
      n_cmp++;
      if (game_over !== (n == 3)) begin n_fail++; $display("FAIL go_flag n=%0d got %b", n, game_over); end
      n_cmp++;
    end
    if (high_score !== 20'h00270) begin n_fail++; $display("FAIL go_high_score got %h expected 00270", high_score); end
    n_cmp++;
    cyc(1'b0, 11'h010, 1'b1);
    repeat (8) cyc(1'b0, 11'd0, 1'b0);
    if (score !== 20'h00270) begin n_fail++; $display("FAIL go_ignored_score got %h expected 00270", score); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL go_ignored_ovf got %b expected 0", overflow); end
    n_cmp++;
    if (lives !== 4'd0) begin n_fail++; $display("FAIL go_ignored_lives got %0d expected 0", lives); end
    n_cmp++;
  endtask

  task automatic test_bonus_ship_lost();
    cyc(1'b1, 11'd0, 1'b0);
    repeat (12) begin
      cyc(1'b0, 11'h799, 1'b0);
      idle_until_model_done();
    end
    if (score !== 20'h09588) begin n_fail++; $display("FAIL bonus_pre_score got %h expected 09588", score); end
    n_cmp++;
    cyc(1'b0, 11'h412, 1'b0);
    repeat (5) cyc(1'b0, 11'd0, 1'b0);
    cyc(1'b0, 11'd0, 1'b1);
    if (extra_life !== 1'b1) begin n_fail++; $display("FAIL bonus_pulse got %b expected 1", extra_life); end
    n_cmp++;
    if (lives !== 4'd3) begin n_fail++; $display("FAIL bonus_lost_lives got %0d expected 3", lives); end
    n_cmp++;
    if (score !== 20'h10000) begin n_fail++; $display("FAIL bonus_score got %h expected 10000", score); end
    n_cmp++;
    cyc(1'b0, 11'd0, 1'b0);
    if (extra_life !== 1'b0) begin n_fail++; $display("FAIL bonus_pulse_end got %b expected 0", extra_life); end
    n_cmp++;
  endtask

  task automatic test_saturate_wrap();
    cyc(1'b1, 11'd0, 1'b0);
    for (int i = 0; i < 130; i++) begin
      cyc(1'b0, 11'h799, 1'b0);
      idle_until_model_done();
      if (score !== to_bcd(m_score)) begin n_fail++; $display("FAIL sat_score i=%0d got %h expected %h", i, score, to_bcd(m_score)); end
      n_cmp++;
      if (lives !== 4'(m_lives)) begin n_fail++; $display("FAIL sat_lives i=%0d got %0d expected %0d", i, lives, m_lives); end
      n_cmp++;
    end
    if (lives !== 4'd9) begin n_fail++; $display("FAIL sat_lives_final got %0d expected 9", lives); end
    n_cmp++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf got %b expected 1", overflow); end
    n_cmp++;
    if (score !== 20'h03870) begin n_fail++; $display("FAIL wrap_score got %h expected 03870", score); end
    n_cmp++;
  endtask

  task automatic test_begin_mid_add();
    cyc(1'b1, 11'd0, 1'b0);
    cyc(1'b0, 11'h555, 1'b0);
    cyc(1'b0, 11'd0, 1'b1);
    cyc(1'b0, 11'd0, 1'b0);
    cyc(1'b1, 11'd0, 1'b0);
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b expected 0", busy); end
    n_cmp++;
    if (lives !== 4'd3) begin n_fail++; $display("FAIL abort_lives got %0d expected 3", lives); end
    n_cmp++;
    repeat (8) cyc(1'b0, 11'd0, 1'b0);
    if (score !== 20'h0) begin n_fail++; $display("FAIL abort_score got %h expected 0", score); end
    n_cmp++;
  endtask

  task automatic test_random();
    logic        gb, sl;
    logic [10:0] p;
    cyc(1'b1, 11'd0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      gb = ($urandom_range(399) == 0) || (m_go == 1 && $urandom_range(19) == 0);
      sl = ($urandom_range(149) == 0);
      p  = ($urandom_range(2) == 0) ?
           {3'($urandom_range(7)), 4'($urandom_range(9)), 4'($urandom_range(9))} : 11'd0;
      cyc(gb, p, sl);
      if (score !== to_bcd(m_score)) begin n_fail++; $display("FAIL rnd_score c=%0d got %h expected %h", c, score, to_bcd(m_score)); end
      n_cmp++;
      if (high_score !== to_bcd(m_hs)) begin n_fail++; $display("FAIL rnd_hs c=%0d got %h expected %h", c, high_score, to_bcd(m_hs)); end
      n_cmp++;
      if (lives !== 4'(m_lives)) begin n_fail++; $display("FAIL rnd_lives c=%0d got %0d expected %0d", c, lives, m_lives); end
      n_cmp++;
      if (extra_life !== 1'(m_xl)) begin n_fail++; $display("FAIL rnd_xl c=%0d got %b expected %0d", c, extra_life, m_xl); end
      n_cmp++;
      if (game_over !== 1'(m_go)) begin n_fail++; $display("FAIL rnd_go c=%0d got %b expected %0d", c, game_over, m_go); end
      n_cmp++;
      if (busy !== (m_rem != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b expected %0d", c, busy, m_rem != 0); end
      n_cmp++;
      if (overflow !== 1'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %b expected %0d", c, overflow, m_ovf); end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_add();
    cyc(1'b1, 11'd0, 1'b0);
    cyc(1'b0, 11'h321, 1'b0);
    cyc(1'b0, 11'd0, 1'b0);
    cyc(1'b0, 11'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b expected 0", busy); end
    n_cmp++;
    if (game_over !== 1'b1) begin n_fail++; $display("FAIL arst_game_over got %b expected 1", game_over); end
    n_cmp++;
    if (lives !== 4'd0) begin n_fail++; $display("FAIL arst_lives got %0d expected 0", lives); end
    n_cmp++;
    if (score !== 20'h0 || high_score !== 20'h0) begin
      n_fail++; $display("FAIL arst_scores got %h/%h expected 0/0", score, high_score);
    end
    n_cmp++;
    if (extra_life !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL arst_flags got %b%b expected 00", extra_life, overflow);
    end
    n_cmp++;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_game_over();
    test_bonus_ship_lost();
    test_saturate_wrap();
    test_begin_mid_add();
    test_random();
    test_reset_mid_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
